// File: rtl/fix_trailer_serializer.sv
// Streams one FIX message body followed by the "10=ddd<SOH>" checksum trailer,
// one byte per valid/ready beat. Holds a single message at a time.
module fix_trailer_serializer #(
   parameter int unsigned FIX_PAYLOAD_LEN = 220,
   parameter int unsigned FIX_HEADER_LEN  = 42,
   parameter int unsigned LEN_W           = 9,
   localparam int unsigned MSG_BYTES      = FIX_PAYLOAD_LEN + FIX_HEADER_LEN
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [MSG_BYTES*8-1:0] in_msg,
   input  logic [LEN_W-1:0]       in_len,
   output logic                   in_ready,
   output logic [7:0]             out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic                   len_err
);

   typedef enum logic [1:0] {StIdle, StBody, StTrailer} state_e;

   state_e                 state_q, state_d;
   logic [MSG_BYTES*8-1:0] msg_q, msg_d;
   logic [LEN_W-1:0]       rem_q, rem_d;
   logic [7:0]             sum_q, sum_d;
   logic [2:0]             t_q, t_d;
   logic                   len_err_q, len_err_d;
   logic                   bad_len;
   logic [7:0]             dig2, dig1, dig0;

   assign bad_len = (in_len == '0) || (in_len > LEN_W'(MSG_BYTES));
   assign dig2    = 8'h30 + sum_q / 8'd100;
   assign dig1    = 8'h30 + (sum_q / 8'd10) % 8'd10;
   assign dig0    = 8'h30 + sum_q % 8'd10;
   assign len_err = len_err_q;

   always_comb begin
      state_d   = state_q;
      msg_d     = msg_q;
      rem_d     = rem_q;
      sum_d     = sum_q;
      t_d       = t_q;
      len_err_d = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = 8'h00;
      out_last  = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = ~rst;
            if (in_valid) begin
               if (bad_len) begin
                  len_err_d = 1'b1;
               end else begin
                  msg_d   = in_msg;
                  rem_d   = in_len - LEN_W'(1);
                  sum_d   = 8'h00;
                  state_d = StBody;
               end
            end
         end
         StBody: begin
            out_valid = 1'b1;
            out_data  = msg_q[MSG_BYTES*8-1 -: 8];
            if (out_ready) begin
               sum_d = sum_q + out_data;
               // The current byte always sits at the top of the shifted message.
               msg_d = msg_q << 8;
               if (rem_q == '0) begin
                  state_d = StTrailer;
                  t_d     = 3'd0;
               end else begin
                  rem_d = rem_q - LEN_W'(1);
               end
            end
         end
         StTrailer: begin
            out_valid = 1'b1;
            out_last  = (t_q == 3'd6);
            case (t_q)
               3'd0:    out_data = 8'h31;
               3'd1:    out_data = 8'h30;
               3'd2:    out_data = 8'h3D;
               3'd3:    out_data = dig2;
               3'd4:    out_data = dig1;
               3'd5:    out_data = dig0;
               default: out_data = 8'h01;
            endcase
            if (out_ready) begin
               if (t_q == 3'd6) state_d = StIdle;
               else             t_d = t_q + 3'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         msg_q     <= '0;
         rem_q     <= '0;
         sum_q     <= '0;
         t_q       <= '0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         msg_q     <= msg_d;
         rem_q     <= rem_d;
         sum_q     <= sum_d;
         t_q       <= t_d;
         len_err_q <= len_err_d;
      end
   end

endmodule

// File: tb/tb_fix_trailer_serializer.sv
// Randomized bench for fix_trailer_serializer: a byte-queue reference model predicts
// every output beat, in_ready, and len_err pulse.
module tb_fix_trailer_serializer;

   localparam int unsigned MsgBytes = 262;
   localparam int unsigned LenW     = 9;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid;
   logic [MsgBytes*8-1:0] in_msg;
   logic [LenW-1:0]       in_len;
   logic                  in_ready;
   logic [7:0]            out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;
   logic                  len_err;

   fix_trailer_serializer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_msg    (in_msg),
      .in_len    (in_len),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .len_err   (len_err)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   byte unsigned exp_q[$];
   bit          err_pend = 1'b0;
   bit          accepted = 1'b0;
   int          ready_mode = 0;
   int          tog = 0;
   int          dut_beats = 0;
   logic [7:0]  msg_b [MsgBytes];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected stream: body bytes, then "10=" + 3 decimal digits of sum mod 256 + SOH.
   task automatic push_msg(input int len);
      int s;
      s = 0;
      for (int k = 0; k < len; k++) begin
         exp_q.push_back(msg_b[k]);
         s = s + int'(msg_b[k]);
      end
      s = s % 256;
      exp_q.push_back(8'h31);
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h3D);
      exp_q.push_back(8'(8'h30 + s / 100));
      exp_q.push_back(8'(8'h30 + (s / 10) % 10));
      exp_q.push_back(8'(8'h30 + s % 10));
      exp_q.push_back(8'h01);
   endtask

   task automatic cycle();
      bit busy;
      bit exp_rdy;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = (tog % 3 == 0);
      endcase
      tog++;
      @(negedge clk);
      busy     = (exp_q.size() != 0);
      exp_rdy  = !busy && !rst;
      accepted = 1'b0;
      check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
      check_val("out_valid", 32'(out_valid), 32'(busy));
      check_val("len_err", 32'(len_err), 32'(err_pend));
      if (busy) begin
         check_val("out_data", 32'(out_data), 32'(exp_q[0]));
         check_val("out_last", 32'(out_last), 32'(exp_q.size() == 1));
      end
      if (out_valid && out_ready) dut_beats++;
      err_pend = 1'b0;
      if (rst) begin
         exp_q.delete();
      end else if (busy) begin
         if (out_ready) void'(exp_q.pop_front());
      end else if (in_valid) begin
         accepted = 1'b1;
         if (in_len == 0 || int'(in_len) > MsgBytes) err_pend = 1'b1;
         else push_msg(int'(in_len));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic fill_rand();
      for (int k = 0; k < MsgBytes; k++) begin
         case ($urandom_range(0, 7))
            0:       msg_b[k] = 8'h00;
            1:       msg_b[k] = 8'h01;
            default: msg_b[k] = 8'($urandom);
         endcase
      end
   endtask

   task automatic send(input int len);
      for (int k = 0; k < MsgBytes; k++) in_msg[(MsgBytes-k)*8-1 -: 8] = msg_b[k];
      in_len   = LenW'(len);
      in_valid = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         cycle();
         if (accepted) break;
      end
      if (!accepted) check_val("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20000; i++) begin
         if (exp_q.size() == 0) break;
         cycle();
      end
      check_val("drain_timeout", 32'(exp_q.size()), 32'd0);
      cycle();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_len    = '0;
      in_msg    = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cycle();
      cycle();
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_out_data", 32'(out_data), 32'h00);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out_last", 32'(out_last), 32'd0);
      check_val("rst_len_err", 32'(len_err), 32'd0);
      check_val("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Single 'A' byte, then four 0xFF bytes.
      fill_rand();
      msg_b[0]  = 8'h41;
      dut_beats = 0;
      send(1);
      drain();
      check_val("t1_beats", 32'(dut_beats), 32'd8);
      fill_rand();
      for (int k = 0; k < 4; k++) msg_b[k] = 8'hFF;
      send(4);
      drain();

      // Stalling sink.
      ready_mode = 2;
      fill_rand();
      msg_b[0]  = 8'h41;
      dut_beats = 0;
      send(1);
      drain();
      check_val("t3_beats", 32'(dut_beats), 32'd8);
      ready_mode = 0;

      // Length boundaries.
      send(0);
      cycle();
      send(263);
      cycle();
      send(511);
      cycle();
      fill_rand();
      send(262);
      drain();

      // Reset mid-body, then a clean message.
      fill_rand();
      send(20);
      dut_beats = 0;
      for (int i = 0; i < 100; i++) begin
         if (dut_beats >= 3) break;
         cycle();
      end
      check_val("t5_beats", 32'(dut_beats), 32'd3);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
      fill_rand();
      msg_b[0] = 8'h41;
      send(1);
      drain();

      // Back-to-back with in_valid held high.
      dut_beats = 0;
      fill_rand();
      send(2);
      fill_rand();
      send(3);
      drain();
      check_val("t6_beats", 32'(dut_beats), 32'd19);

      // Random traffic.
      for (int m = 0; m < 25; m++) begin
         int len;
         ready_mode = int'($urandom_range(0, 2));
         fill_rand();
         if ($urandom_range(0, 7) == 0)
            len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(263, 511));
         else if ($urandom_range(0, 9) == 0)
            len = int'($urandom_range(1, MsgBytes));
         else
            len = int'($urandom_range(1, 24));
         send(len);
         if ($urandom_range(0, 1) == 0) drain();
      end
      ready_mode = 0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
